nn_mem_reader: RTL and testbench

Read-side sequencer for the neural-network memory system. On `start_compute` it walks every bank select of a `mem_sys` instance, issues single-bit reads over the addr/sel/rw port, and packs the returned bits into words. It hands each word to the compute module over a valid/ready handshake. It mirrors the bench-side loader: the loader writes bits 0..WORD_LEN-1 into each bank, and this block reads them back in the same order.

---
 rtl/nn_mem_reader.sv | 99 +++++++++
 tb/tb_nn_mem_reader.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/nn_mem_reader.sv
// nn_mem_reader: walks every bank of the memory with single-bit reads and
// hands each packed word to the compute module over a valid/ready handshake.
module nn_mem_reader #(
  parameter int ADDR_LEN = 20,
  parameter int SEL_LEN  = 2,
  parameter int RW_LEN   = 2,
  parameter int NUM_SEL  = 4,
  parameter int WORD_LEN = 8,
  parameter int RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_compute,
  output logic                busy,
  output logic                done,
  output logic [ADDR_LEN-1:0] rd_addr,
  output logic [SEL_LEN-1:0]  rd_sel,
  output logic [RW_LEN-1:0]   rd_rw,
  input  logic                rd_data,
  output logic [WORD_LEN-1:0] word_data,
  output logic [SEL_LEN-1:0]  word_sel,
  output logic                word_valid,
  input  logic                word_ready
);
  localparam int IW = WORD_LEN > 1 ? $clog2(WORD_LEN) : 1;
  localparam logic [RW_LEN-1:0] RD = RW_LEN'(2);
  localparam logic [ADDR_LEN-1:0] LAST_ADDR = ADDR_LEN'(WORD_LEN - 1);
  localparam logic [SEL_LEN-1:0] LAST_BANK = SEL_LEN'(NUM_SEL - 1);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_PRESENT, S_DONE} state_t;
  state_t state;
  logic [SEL_LEN-1:0] bank;
  logic [RD_LAT-1:0] tag_v;
  logic [IW-1:0] tag_i [RD_LAT];
  assign rd_sel = bank;
  assign word_sel = bank;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= S_IDLE;
      bank <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      rd_addr <= '0;
      rd_rw <= '0;
      word_data <= '0;
      word_valid <= 1'b0;
      tag_v <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_i[i] <= '0;
    end else begin
      // each issued read is tagged with its bit index and retired RD_LAT edges later
      tag_v[0] <= state == S_ISSUE;
      tag_i[0] <= rd_addr[IW-1:0];
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_i[i] <= tag_i[i-1];
      end
      if (tag_v[RD_LAT-1]) word_data[tag_i[RD_LAT-1]] <= rd_data;
      case (state)
        S_IDLE:
          if (start_compute) begin
            state <= S_ISSUE;
            bank <= '0;
            busy <= 1'b1;
            rd_rw <= RD;
            rd_addr <= '0;
            word_data <= '0;
          end
        S_ISSUE:
          if (rd_addr == LAST_ADDR) begin
            state <= S_DRAIN;
            rd_rw <= '0;
            rd_addr <= '0;
          end else rd_addr <= rd_addr + 1'b1;
        S_DRAIN:
          if (tag_v[RD_LAT-1] && tag_i[RD_LAT-1] == IW'(WORD_LEN - 1)) begin
            state <= S_PRESENT;
            word_valid <= 1'b1;
          end
        S_PRESENT:
          if (word_ready) begin
            word_valid <= 1'b0;
            if (bank == LAST_BANK) begin
              state <= S_DONE;
              done <= 1'b1;
            end else begin
              state <= S_ISSUE;
              bank <= bank + 1'b1;
              rd_rw <= RD;
              word_data <= '0;
            end
          end
        S_DONE: begin
          state <= S_IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_nn_mem_reader.sv
// tb_nn_mem_reader: directed checks of the bank-walking reader against
// behavioural memories with read latency 1 and 3.
module tb_nn_mem_reader;
  logic clk = 0, rst = 0, start = 0, ready = 1, start2 = 0;
  logic busy, done, rd_data = 0, word_valid;
  logic [19:0] rd_addr;
  logic [1:0] rd_sel, rd_rw, word_sel;
  logic [7:0] word_data;
  logic busy2, done2, rd_data2, word_valid2;
  logic [19:0] rd_addr2;
  logic [1:0] rd_sel2, rd_rw2, word_sel2;
  logic [7:0] word_data2;
  logic [2:0] pipe2 = '0;
  logic [7:0] mem1 [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
  logic [7:0] mem2 [4] = '{8'h81, 8'h13, 8'h6E, 8'hF0};
  int ecount = 0, total = 0, passed = 0, base = 0;
  int rw1 = 0, stall = 0, stall_bad = 0;
  logic prev_v = 0, prev_v2 = 0;
  logic [9:0] wq [$];
  logic [9:0] w2q [$];
  int vr [$];
  int dq [$];
  int vr2 [$];
  int d2q [$];
  always #5 clk = ~clk;
  nn_mem_reader u_dut (
    .clk(clk), .rst(rst), .start_compute(start), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_rw(rd_rw), .rd_data(rd_data),
    .word_data(word_data), .word_sel(word_sel), .word_valid(word_valid), .word_ready(ready)
  );
  nn_mem_reader #(.RD_LAT(3)) u_lat (
    .clk(clk), .rst(rst), .start_compute(start2), .busy(busy2), .done(done2),
    .rd_addr(rd_addr2), .rd_sel(rd_sel2), .rd_rw(rd_rw2), .rd_data(rd_data2),
    .word_data(word_data2), .word_sel(word_sel2), .word_valid(word_valid2), .word_ready(1'b1)
  );
  always @(posedge clk) begin
    ecount++;
    rd_data <= rd_rw == 2'd2 ? mem1[rd_sel][rd_addr[2:0]] : 1'b0;
    pipe2 <= {pipe2[1:0], rd_rw2 == 2'd2 ? mem2[rd_sel2][rd_addr2[2:0]] : 1'b0};
  end
  assign rd_data2 = pipe2[2];
  always @(negedge clk)
    if (rst) begin
      if (rd_rw == 2'd1 || rd_rw2 == 2'd1) rw1++;
      if (word_valid && !prev_v) vr.push_back(ecount);
      if (word_valid && ready) wq.push_back({word_sel, word_data});
      if (word_valid && !ready) begin
        stall++;
        if (word_data !== 8'h3C || word_sel !== 2'd1 || rd_rw !== 2'd0) stall_bad++;
      end
      if (done) dq.push_back(ecount);
      if (word_valid2 && !prev_v2) vr2.push_back(ecount);
      if (word_valid2) w2q.push_back({word_sel2, word_data2});
      if (done2) d2q.push_back(ecount);
      prev_v = word_valid;
      prev_v2 = word_valid2;
    end
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " rd_addr"}, int'(rd_addr), 0);
    chk({tag, " rd_sel"}, int'(rd_sel), 0);
    chk({tag, " rd_rw"}, int'(rd_rw), 0);
    chk({tag, " word_data"}, int'(word_data), 0);
    chk({tag, " word_sel"}, int'(word_sel), 0);
    chk({tag, " word_valid"}, int'(word_valid), 0);
  endtask
  task automatic check_run(input string tag, input int i0, input int v0, input int d0, input int exp_done);
    chk({tag, " nwords"}, wq.size() - i0, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s word%0d", tag, i), i0 + i < wq.size() ? int'(wq[i0 + i]) : -1, int'({2'(i), mem1[i]}));
    chk({tag, " first_valid"}, vr.size() > v0 ? vr[v0] - base + 1 : -1, 10);
    chk({tag, " ndone"}, dq.size() - d0, 1);
    chk({tag, " done_cycle"}, dq.size() > d0 ? dq[d0] - base + 1 : -1, exp_done);
    chk({tag, " rw_write"}, rw1, 0);
  endtask
  task automatic start_run;
    start = 1;
    tick();
    start = 0;
    base = ecount;
  endtask
  task automatic wait_done(input int d0);
    for (int i = 0; i < 200 && dq.size() == d0; i++) tick();
  endtask
  initial begin
    int i0, v0, d0, s0;
    tick();
    tick();
    chk_reset("reset");
    rst = 1;
    tick();
    // basic run
    i0 = wq.size(); v0 = vr.size(); d0 = dq.size();
    start_run();
    chk("c1 rd_rw", int'(rd_rw), 2);
    chk("c1 rd_addr", int'(rd_addr), 0);
    chk("c1 busy", int'(busy), 1);
    tick();
    chk("c2 rd_addr", int'(rd_addr), 1);
    wait_done(d0);
    chk("after done busy", int'(busy), 0);
    chk("after done done", int'(done), 0);
    check_run("basic", i0, v0, d0, 41);
    // back-to-back: start in the cycle after done
    i0 = wq.size(); v0 = vr.size(); d0 = dq.size();
    start_run();
    chk("b2b c1 rd_rw", int'(rd_rw), 2);
    wait_done(d0);
    tick();
    check_run("b2b", i0, v0, d0, 41);
    tick();
    // backpressure on bank 1 plus ignored starts in cycles 3 and 20
    i0 = wq.size(); v0 = vr.size(); d0 = dq.size(); s0 = stall;
    start_run();
    for (int c = 2; c <= 60; c++) begin
      tick();
      start = c == 3 || c == 20;
      ready = !(c >= 20 && c <= 24);
    end
    start = 0;
    ready = 1;
    check_run("stall", i0, v0, d0, 46);
    chk("stall cycles", stall - s0, 5);
    chk("stall stable", stall_bad, 0);
    // reset in cycle 6 aborts the run
    i0 = wq.size();
    start_run();
    for (int c = 2; c <= 6; c++) tick();
    rst = 0;
    #1;
    chk_reset("midreset");
    tick();
    tick();
    rst = 1;
    tick();
    tick();
    tick();
    chk("post reset valid", int'(word_valid), 0);
    chk("post reset busy", int'(busy), 0);
    chk("post reset words", wq.size() - i0, 0);
    i0 = wq.size(); v0 = vr.size(); d0 = dq.size();
    start_run();
    wait_done(d0);
    tick();
    check_run("rerun", i0, v0, d0, 41);
    // read latency 3
    i0 = w2q.size(); v0 = vr2.size(); d0 = d2q.size();
    start2 = 1;
    tick();
    start2 = 0;
    base = ecount;
    for (int i = 0; i < 200 && d2q.size() == d0; i++) tick();
    chk("lat3 nwords", w2q.size() - i0, 4);
    chk("lat3 word0", w2q.size() > i0 ? int'(w2q[i0]) : -1, 'h081);
    chk("lat3 word1", w2q.size() > i0 + 1 ? int'(w2q[i0 + 1]) : -1, 'h113);
    chk("lat3 first_valid", vr2.size() > v0 ? vr2[v0] - base + 1 : -1, 12);
    chk("lat3 done_cycle", d2q.size() > d0 ? d2q[d0] - base + 1 : -1, 49);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
